// File: rtl/disparity_sad_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// disparity_sad_engine: loads a stereo frame pair from a pixel stream and
// builds a full-frame SAD block-matching disparity map.   Revision: 1.0
// ----------------------------------------------------------------------------
module disparity_sad_engine #(
  parameter int PIX_W      = 8,
  parameter int WIDTH      = 20,
  parameter int HEIGHT     = 7,
  parameter int HALF_BLOCK = 2,
  parameter int MAX_DISP   = 15,
  parameter int DISP_W     = 4,
  parameter int SAD_W      = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ref_right,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              busy,
  output logic              done,
  input  logic [9:0]        rd_col,
  input  logic [9:0]        rd_row,
  output logic [DISP_W-1:0] disp_out,
  output logic [SAD_W-1:0]  sad_out
);
  localparam int BLOCK = 2*HALF_BLOCK + 1;
  localparam int NPIX  = WIDTH*HEIGHT;
  localparam int AW    = $clog2(NPIX);
  localparam int WW    = $clog2(BLOCK + 1);
  localparam int SW1   = SAD_W + 1;
  localparam logic [SAD_W-1:0] SAD_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOAD_L, LOAD_R, SAD, CMP, WRITE, DONE} state_t;
  state_t r_state, w_next;

  logic [PIX_W-1:0]  r_left     [NPIX];
  logic [PIX_W-1:0]  r_right    [NPIX];
  logic [DISP_W-1:0] r_disp_mem [NPIX];
  logic [SAD_W-1:0]  r_sad_mem  [NPIX];

  logic [AW-1:0]     r_lidx;
  logic [9:0]        r_col, r_row;
  logic [DISP_W-1:0] r_d, r_best_d;
  logic [WW-1:0]     r_wx, r_wy;
  logic [SAD_W-1:0]  r_acc, r_best;
  logic              r_ref_right;

  int               w_rx, w_ry, w_sx, w_nd;
  logic             w_tap_ok, w_load_last, w_last_tap, w_last_pix, w_next_d_ok, w_better;
  logic [AW-1:0]    w_ref_idx, w_srch_idx, w_pix_idx, w_rd_idx;
  logic [PIX_W-1:0] w_ref_pix, w_srch_pix, w_diff;
  logic [SAD_W:0]   w_sum;

  // Window tap fetch: a tap counts only when both the reference and search pixels are in-frame.
  always_comb begin
    w_rx       = int'(r_col) + int'(r_wx) - HALF_BLOCK;
    w_ry       = int'(r_row) + int'(r_wy) - HALF_BLOCK;
    w_sx       = r_ref_right ? (w_rx + int'(r_d)) : (w_rx - int'(r_d));
    w_tap_ok   = (w_rx >= 0) && (w_rx < WIDTH) && (w_sx >= 0) && (w_sx < WIDTH) &&
                 (w_ry >= 0) && (w_ry < HEIGHT);
    w_ref_idx  = '0;
    w_srch_idx = '0;
    if (w_tap_ok) begin
      w_ref_idx  = AW'(w_ry*WIDTH + w_rx);
      w_srch_idx = AW'(w_ry*WIDTH + w_sx);
    end
    w_ref_pix  = r_ref_right ? r_right[w_ref_idx] : r_left[w_ref_idx];
    w_srch_pix = r_ref_right ? r_left[w_srch_idx] : r_right[w_srch_idx];
    w_diff     = (w_ref_pix > w_srch_pix) ? (w_ref_pix - w_srch_pix) : (w_srch_pix - w_ref_pix);
    if (!w_tap_ok) w_diff = '0;
    w_sum      = {1'b0, r_acc} + SW1'(w_diff);
  end

  always_comb begin
    w_load_last = pix_valid && (r_lidx == AW'(NPIX-1));
    w_last_tap  = (r_wx == WW'(BLOCK-1)) && (r_wy == WW'(BLOCK-1));
    w_last_pix  = (r_col == 10'(WIDTH-1)) && (r_row == 10'(HEIGHT-1));
    w_nd        = int'(r_d) + 1;
    w_next_d_ok = (w_nd <= MAX_DISP) &&
                  (r_ref_right ? (int'(r_col) + w_nd <= WIDTH-1) : (w_nd <= int'(r_col)));
    w_better    = (r_d == '0) || (r_acc < r_best);
    w_pix_idx   = AW'(int'(r_row)*WIDTH + int'(r_col));
    w_rd_idx    = AW'(int'(rd_row)*WIDTH + int'(rd_col));
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    pix_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = LOAD_L;
      end
      LOAD_L: begin
        pix_ready = 1'b1;
        if (w_load_last) w_next = LOAD_R;
      end
      LOAD_R: begin
        pix_ready = 1'b1;
        if (w_load_last) w_next = SAD;
      end
      SAD:   if (w_last_tap) w_next = CMP;
      CMP:   w_next = w_next_d_ok ? SAD : WRITE;
      WRITE: w_next = w_last_pix ? DONE : SAD;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) w_next = LOAD_L;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lidx      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_d         <= '0;
      r_best_d    <= '0;
      r_wx        <= '0;
      r_wy        <= '0;
      r_acc       <= '0;
      r_best      <= '0;
      r_ref_right <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_ref_right <= ref_right;
          r_lidx      <= '0;
        end
        LOAD_L, LOAD_R: if (pix_valid) begin
          r_lidx <= w_load_last ? '0 : (r_lidx + AW'(1));
          r_col  <= '0;
          r_row  <= '0;
          r_d    <= '0;
          r_wx   <= '0;
          r_wy   <= '0;
          r_acc  <= '0;
        end
        SAD: begin
          r_acc <= w_sum[SAD_W] ? SAD_MAX : w_sum[SAD_W-1:0];
          if (w_last_tap) begin
            r_wx <= '0;
            r_wy <= '0;
          end else if (r_wx == WW'(BLOCK-1)) begin
            r_wx <= '0;
            r_wy <= r_wy + WW'(1);
          end else begin
            r_wx <= r_wx + WW'(1);
          end
        end
        CMP: begin
          if (w_better) begin
            r_best   <= r_acc;
            r_best_d <= r_d;
          end
          r_acc <= '0;
          r_d   <= r_d + DISP_W'(1);
        end
        WRITE: begin
          r_d   <= '0;
          r_acc <= '0;
          if (r_col == 10'(WIDTH-1)) begin
            r_col <= '0;
            r_row <= r_row + 10'd1;
          end else begin
            r_col <= r_col + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame and result stores carry no reset.
  always_ff @(posedge clk) begin
    if (!reset && pix_valid && (r_state == LOAD_L)) r_left[r_lidx]  <= pix_in;
    if (!reset && pix_valid && (r_state == LOAD_R)) r_right[r_lidx] <= pix_in;
    if (!reset && (r_state == WRITE)) begin
      r_disp_mem[w_pix_idx] <= r_best_d;
      r_sad_mem[w_pix_idx]  <= r_best;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_out <= '0;
      sad_out  <= '0;
    end else if ((int'(rd_col) < WIDTH) && (int'(rd_row) < HEIGHT)) begin
      disp_out <= r_disp_mem[w_rd_idx];
      sad_out  <= r_sad_mem[w_rd_idx];
    end else begin
      disp_out <= '0;
      sad_out  <= '0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_disparity_sad_engine.sv
`default_nettype none
// tb_disparity_sad_engine: scenario table plus a loop-based SAD reference model.
module tb_disparity_sad_engine;
  localparam int W = 8, H = 4, HB = 1, MD = 3;
  localparam int B = 2*HB + 1, NP = W*H, SMAX = 4095;

  logic        clk = 1'b0;
  logic        reset, start, ref_right, pix_valid, pix_ready, busy, done;
  logic [7:0]  pix_in;
  logic [9:0]  rd_col, rd_row;
  logic [1:0]  disp_out;
  logic [11:0] sad_out;

  always #5 clk = ~clk;

  disparity_sad_engine #(
    .PIX_W(8), .WIDTH(W), .HEIGHT(H), .HALF_BLOCK(HB), .MAX_DISP(MD), .DISP_W(2), .SAD_W(12)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ref_right(ref_right),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .done(done), .rd_col(rd_col), .rd_row(rd_row),
    .disp_out(disp_out), .sad_out(sad_out)
  );

  typedef struct {int pat; int rr; int gaps; int poke;} scen_t;
  typedef struct {int scen; int c; int r; int disp; int sad;} vec_t;
  localparam int NSC = 7, NHV = 14;
  scen_t sc[NSC];
  vec_t  hv[NHV];
  int    lf[NP], rf[NP];
  int    npass = 0, ntotal = 0;

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Patterns: 0 flat, 1 ramp shifted by two columns, 2 black vs white,
  // 3 random left / white right, 4 both random.
  task automatic set_frames(input int pat);
    for (int i = 0; i < NP; i++) begin
      int c;
      c = i % W;
      case (pat)
        0: begin lf[i] = 'h40; rf[i] = 'h40; end
        1: begin lf[i] = 16*c; rf[i] = 16*(c+2); end
        2: begin lf[i] = 0; rf[i] = 255; end
        3: begin lf[i] = int'($urandom_range(0, 255)); rf[i] = 255; end
        default: begin lf[i] = int'($urandom_range(0, 255)); rf[i] = int'($urandom_range(0, 255)); end
      endcase
    end
  endtask

  task automatic model(input int c, input int r, input int rr,
                       output int bd, output int bs, output int nv);
    bd = 0; bs = 0; nv = 0;
    for (int d = 0; d <= MD; d++) begin
      int s, scol;
      scol = (rr != 0) ? c + d : c - d;
      if (scol < 0 || scol >= W) continue;
      nv++;
      s = 0;
      for (int y = r - HB; y <= r + HB; y++) begin
        for (int x = c - HB; x <= c + HB; x++) begin
          int xs, a, b;
          xs = (rr != 0) ? x + d : x - d;
          if (y >= 0 && y < H && x >= 0 && x < W && xs >= 0 && xs < W) begin
            a = (rr != 0) ? rf[y*W + x] : lf[y*W + x];
            b = (rr != 0) ? lf[y*W + xs] : rf[y*W + xs];
            s += (a > b) ? a - b : b - a;
          end
        end
      end
      if (s > SMAX) s = SMAX;
      if (nv == 1 || s < bs) begin bs = s; bd = d; end
    end
  endtask

  task automatic run(input int idx);
    int xfers, cyc, exp_cyc, bd, bs, nv;
    logic rdy;
    set_frames(sc[idx].pat);
    ref_right = (sc[idx].rr != 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ref_right = ~ref_right;
    chk($sformatf("s%0d_busy_after_start", idx), busy, 1);
    xfers = 0;
    for (int i = 0; i < 2*NP; i++) begin
      if (sc[idx].gaps != 0) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      pix_in = 8'((i < NP) ? lf[i] : rf[i-NP]);
      pix_valid = 1'b1;
      rdy = pix_ready;
      @(posedge clk); #1;
      if (rdy) xfers++;
    end
    pix_valid = 1'b0;
    chk($sformatf("s%0d_ready_transfers", idx), xfers, 2*NP);
    chk($sformatf("s%0d_ready_after_load", idx), pix_ready, 0);
    exp_cyc = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        model(c, r, sc[idx].rr, bd, bs, nv);
        exp_cyc += nv*(B*B + 1) + 1;
      end
    cyc = 0;
    while (!done && cyc < 20000) begin
      start = (sc[idx].poke != 0) && (cyc == 40);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("s%0d_compute_cycles", idx), cyc, exp_cyc);
    chk($sformatf("s%0d_busy_at_done", idx), busy, 0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        rd_col = 10'(c);
        rd_row = 10'(r);
        @(posedge clk); #1;
        model(c, r, sc[idx].rr, bd, bs, nv);
        chk($sformatf("s%0d_disp(%0d,%0d)", idx, c, r), disp_out, bd);
        chk($sformatf("s%0d_sad(%0d,%0d)", idx, c, r), sad_out, bs);
      end
    for (int k = 0; k < NHV; k++)
      if (hv[k].scen == idx) begin
        rd_col = 10'(hv[k].c);
        rd_row = 10'(hv[k].r);
        @(posedge clk); #1;
        chk($sformatf("hv%0d_disp", k), disp_out, hv[k].disp);
        chk($sformatf("hv%0d_sad", k), sad_out, hv[k].sad);
      end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // With the right frame as reference the search runs rightwards, so the
    // shifted-ramp frames give the d=2 match in both directions.
    sc[0] = '{0, 0, 0, 0};
    sc[1] = '{1, 0, 0, 0};
    sc[2] = '{1, 1, 0, 0};
    sc[3] = '{1, 0, 1, 0};
    sc[4] = '{3, 0, 0, 1};
    sc[5] = '{4, 1, 0, 0};
    sc[6] = '{2, 0, 0, 0};
    hv[0]  = '{0, 0, 0, 0, 0};
    hv[1]  = '{0, 7, 3, 0, 0};
    hv[2]  = '{1, 0, 0, 0, 128};
    hv[3]  = '{1, 1, 1, 1, 96};
    hv[4]  = '{1, 2, 1, 2, 0};
    hv[5]  = '{1, 5, 1, 2, 0};
    hv[6]  = '{1, 3, 2, 2, 0};
    hv[7]  = '{1, 7, 0, 2, 0};
    hv[8]  = '{2, 0, 1, 2, 0};
    hv[9]  = '{2, 3, 2, 2, 0};
    hv[10] = '{2, 7, 0, 0, 128};
    hv[11] = '{2, 6, 1, 1, 96};
    hv[12] = '{6, 5, 1, 0, 2295};
    hv[13] = '{6, 7, 1, 0, 1530};

    reset = 1'b1; start = 1'b0; ref_right = 1'b0; pix_valid = 1'b0;
    pix_in = '0; rd_col = '0; rd_row = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_disp_out", disp_out, 0);
    chk("rst_sad_out", sad_out, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int s = 0; s < NSC; s++) run(s);

    // Out-of-range reads, then reset from DONE clears outputs.
    rd_col = 10'd8; rd_row = 10'd1;
    @(posedge clk); #1;
    chk("oor_col_sad", sad_out, 0);
    rd_col = 10'd5; rd_row = 10'd4;
    @(posedge clk); #1;
    chk("oor_row_sad", sad_out, 0);
    rd_col = 10'd1023; rd_row = 10'd0;
    @(posedge clk); #1;
    chk("oor_far_sad", sad_out, 0);
    rd_col = 10'd5; rd_row = 10'd1;
    @(posedge clk); #1;
    chk("pre_reset_sad", sad_out, 2295);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_done_clear", done, 0);
    chk("reset_sad_clear", sad_out, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of the SAD phase, with start asserted alongside it.
    set_frames(0);
    ref_right = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2*NP; i++) begin
      pix_in = 8'((i < NP) ? lf[i] : rf[i-NP]);
      pix_valid = 1'b1;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_done", done, 0);
    chk("mid_reset_ready", pix_ready, 0);
    @(posedge clk); #1;
    chk("start_with_reset_ignored", busy, 0);
    run(0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
`default_nettype wire
